controle_exibicao_sequencia: RTL and testbench

Controller that plays the stored Genius sequence back to the player before each round. It sweeps the sequence memory address from 0 to the current round, and for each entry raises a LED-enable window then a blank gap. It sits between the main game FSM (unidade_controle) and the datapath memory/LED path, and returns a one-cycle `pronto` when playback ends.

---
 rtl/controle_exibicao_sequencia_pkg.sv | 41 ++++
 rtl/controle_exibicao_sequencia_temporizador.sv | 31 +++
 rtl/controle_exibicao_sequencia.sv | 166 ++++++++++++++++
 tb/tb_controle_exibicao_sequencia.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_exibicao_sequencia_pkg.sv
// Shared definitions for the Genius sequence playback controller.
// Holds the state codes (also shown on the HEX debug display), the
// db_estado width, the default timing constants and the helper that
// computes the accelerated LED on-time.
package controle_exibicao_sequencia_pkg;

  localparam int unsigned DB_ESTADO_W = 4;

  localparam int unsigned T_ACESO_PADRAO   = 1000;
  localparam int unsigned T_APAGADO_PADRAO = 500;
  localparam int unsigned T_PASSO_PADRAO   = 50;
  localparam int unsigned T_MIN_PADRAO     = 200;

  typedef enum logic [DB_ESTADO_W-1:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  // max(t_min, t_aceso - rodada*t_passo), evaluated at 64 bits so the
  // product cannot overflow and the subtraction never underflows.
  function automatic longint unsigned tempo_aceso_acelerado(
    input longint unsigned rodada,
    input longint unsigned t_aceso,
    input longint unsigned t_passo,
    input longint unsigned t_min
  );
    longint unsigned reducao;
    reducao = rodada * t_passo;
    if (reducao >= t_aceso)
      return t_min;
    else if ((t_aceso - reducao) < t_min)
      return t_min;
    else
      return t_aceso - reducao;
  endfunction

endpackage

// File: rtl/controle_exibicao_sequencia_temporizador.sv
// temporizador_exibicao: up-counter timing the LED on/off windows.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset (count := 0)
//   zera   - synchronous clear, has priority over conta
//   conta  - count enable
//   limite - window length in cycles (>= 1)
//   fim    - high while count == limite-1 (last cycle of the window)
module temporizador_exibicao #(
  parameter int unsigned LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  input  logic [LARGURA-1:0] limite,
  output logic               fim
);

  logic [LARGURA-1:0] contagem;

  always_ff @(posedge clock) begin
    if (reset || zera)
      contagem <= '0;
    else if (conta)
      contagem <= contagem + 1'b1;
  end

  assign fim = (contagem == (limite - 1'b1));

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// controle_exibicao_sequencia: plays the stored Genius sequence back to
// the player. Sweeps endereco from 0 to the latched round, lighting the
// LED for an on-window and then blanking it for an off-window per entry.
// Optional macro EXIBICAO_ACELERADA_EN: on-time shrinks with the round
// number, latched at start as max(T_MIN, T_ACESO - rodada*T_PASSO).
// Ports:
//   clock      - system clock
//   reset      - synchronous active-high reset
//   iniciar    - start request (only honoured when idle)
//   abortar    - cancel playback, back to idle next edge, no pronto
//   rodada     - last address to show (inclusive), latched at start
//   endereco   - memory read address
//   mostra_led - LED shows memory data (registered)
//   ocupado    - high in every state except OCIOSO
//   pronto     - one-cycle pulse at the end of playback
//   db_estado  - current state code for the HEX display
module controle_exibicao_sequencia
  import controle_exibicao_sequencia_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
  parameter int unsigned T_APAGADO = T_APAGADO_PADRAO,
  parameter int unsigned T_PASSO   = T_PASSO_PADRAO,
  parameter int unsigned T_MIN     = T_MIN_PADRAO
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   abortar,
  input  logic [ADDR_W-1:0]      rodada,
  output logic [ADDR_W-1:0]      endereco,
  output logic                   mostra_led,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  localparam int unsigned T_MAIOR = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int unsigned TW      = $clog2(T_MAIOR + 1);

  if (T_ACESO < 1 || T_APAGADO < 1) begin : g_chk_tempos
    $error("T_ACESO and T_APAGADO must be at least 1");
  end

  estado_t           estado, estado_prox;
  logic [ADDR_W-1:0] rod_r;
  logic              inicia, incrementa;
  logic              zera_tempo, conta_tempo, fim_tempo;
  logic [TW-1:0]     t_aceso, limite;

  // ---------------------------------------------------------------- on-time
`ifdef EXIBICAO_ACELERADA_EN
  if (T_MIN < 1 || T_MIN > T_ACESO) begin : g_chk_min
    $error("T_MIN must be in 1..T_ACESO");
  end

  logic [TW-1:0] t_aceso_r;

  always_ff @(posedge clock) begin
    if (reset)
      t_aceso_r <= TW'(T_ACESO);
    else if (inicia)
      t_aceso_r <= TW'(tempo_aceso_acelerado(64'(rodada), 64'(T_ACESO),
                                             64'(T_PASSO), 64'(T_MIN)));
  end

  assign t_aceso = t_aceso_r;
`else
  assign t_aceso = TW'(T_ACESO);
`endif

  assign limite = (estado == ACESO) ? t_aceso : TW'(T_APAGADO);

  temporizador_exibicao #(
    .LARGURA (TW)
  ) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera_tempo),
    .conta  (conta_tempo),
    .limite (limite),
    .fim    (fim_tempo)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset)
      estado <= OCIOSO;
    else
      estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    inicia      = 1'b0;
    incrementa  = 1'b0;
    zera_tempo  = 1'b0;
    conta_tempo = 1'b0;
    if (abortar) begin
      estado_prox = OCIOSO;
      zera_tempo  = 1'b1;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            estado_prox = CARREGA;
            inicia      = 1'b1;
            zera_tempo  = 1'b1;
          end
        end
        CARREGA: begin
          estado_prox = ACESO;
          zera_tempo  = 1'b1;
        end
        ACESO: begin
          if (fim_tempo) begin
            estado_prox = APAGADO;
            zera_tempo  = 1'b1;
          end else begin
            conta_tempo = 1'b1;
          end
        end
        APAGADO: begin
          if (fim_tempo) begin
            // exit test precedes the increment, so endereco never wraps
            estado_prox = (endereco == rod_r) ? FIM : PROXIMO;
            zera_tempo  = 1'b1;
          end else begin
            conta_tempo = 1'b1;
          end
        end
        PROXIMO: begin
          estado_prox = CARREGA;
          incrementa  = 1'b1;
        end
        FIM:     estado_prox = OCIOSO;
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  // ------------------------------------------------- datapath / outputs
  // Outputs are registered from estado_prox so they line up with estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      endereco   <= '0;
      rod_r      <= '0;
      mostra_led <= 1'b0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
      db_estado  <= '0;
    end else begin
      if (inicia) begin
        endereco <= '0;
        rod_r    <= rodada;
      end else if (incrementa) begin
        endereco <= endereco + 1'b1;
      end
      mostra_led <= (estado_prox == ACESO);
      ocupado    <= (estado_prox != OCIOSO);
      pronto     <= (estado_prox == FIM);
      db_estado  <= estado_prox;
    end
  end

endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// Self-checking bench for controle_exibicao_sequencia with
// T_ACESO=4, T_APAGADO=2, T_PASSO=1, T_MIN=2. Honours EXIBICAO_ACELERADA_EN.
module tb_controle_exibicao_sequencia;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned T_ACESO   = 4;
  localparam int unsigned T_APAGADO = 2;
  localparam int unsigned T_PASSO   = 1;
  localparam int unsigned T_MIN     = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              iniciar = 1'b0;
  logic              abortar = 1'b0;
  logic [ADDR_W-1:0] rodada = '0;
  logic [ADDR_W-1:0] endereco;
  logic              mostra_led, ocupado, pronto;
  logic [3:0]        db_estado;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  controle_exibicao_sequencia #(
    .ADDR_W    (ADDR_W),
    .T_ACESO   (T_ACESO),
    .T_APAGADO (T_APAGADO),
    .T_PASSO   (T_PASSO),
    .T_MIN     (T_MIN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .abortar    (abortar),
    .rodada     (rodada),
    .endereco   (endereco),
    .mostra_led (mostra_led),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .db_estado  (db_estado)
  );

  task automatic check(input string nome, input int atual, input int esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  // One queue entry per cycle of playback: state code + address shown.
  typedef struct {
    int estado;
    int ender;
  } passo_t;

  passo_t fila[$];
  passo_t esp = '{0, 0};
  bit     modelo_ativo = 1'b0;

  function automatic int tempo_aceso(input int r);
`ifdef EXIBICAO_ACELERADA_EN
    int t;
    t = int'(T_ACESO) - r * int'(T_PASSO);
    return (t < int'(T_MIN)) ? int'(T_MIN) : t;
`else
    return int'(T_ACESO);
`endif
  endfunction

  function automatic void planeja(input int r);
    int ton;
    ton = tempo_aceso(r);
    for (int i = 0; i <= r; i++) begin
      fila.push_back('{1, i});
      for (int c = 0; c < ton; c++) fila.push_back('{2, i});
      for (int c = 0; c < int'(T_APAGADO); c++) fila.push_back('{3, i});
      if (i < r) fila.push_back('{4, i});
    end
    fila.push_back('{5, r});
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      fila.delete();
      esp = '{0, 0};
      modelo_ativo = 1'b1;
    end else if (abortar) begin
      fila.delete();
      esp.estado = 0;
    end else if (fila.size() > 0) begin
      esp = fila.pop_front();
    end else if (esp.estado == 0 && iniciar) begin
      planeja(int'(rodada));
      esp = fila.pop_front();
    end else begin
      esp.estado = 0;
    end
  end

  always @(negedge clock) begin
    if (modelo_ativo) begin
      check("endereco",   int'(endereco),   esp.ender);
      check("db_estado",  int'(db_estado),  esp.estado);
      check("mostra_led", int'(mostra_led), int'(esp.estado == 2));
      check("ocupado",    int'(ocupado),    int'(esp.estado != 0));
      check("pronto",     int'(pronto),     int'(esp.estado == 5));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic espera(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Leaves the bench #1 after edge k, the edge that samples iniciar.
  task automatic inicia_reproducao(input int r);
    @(posedge clock);
    #1;
    rodada  = ADDR_W'(r);
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
  endtask

  // Watches cycles c0+1.. (offsets from edge k) until pronto, bounded.
  task automatic observa(input int c0, input int limite,
                         output int p, output int l, output int m);
    p = -1;
    l = 0;
    m = 0;
    for (int c = c0 + 1; c <= limite; c++) begin
      @(negedge clock);
      if (mostra_led) l++;
      if (int'(endereco) > m) m = int'(endereco);
      if (pronto) begin
        p = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, l, m;

    espera(3);
    reset = 1'b0;
    @(negedge clock);
    check("reset_endereco", int'(endereco), 0);
    check("reset_ocupado",  int'(ocupado),  0);
    check("reset_db",       int'(db_estado), 0);

    // single entry
    inicia_reproducao(0);
    observa(0, 60, p, l, m);
    check("r0_pronto_ciclo", p, 8);
    check("r0_leds", l, 4);
    check("r0_end_max", m, 0);
    espera(3);

    // three entries
    inicia_reproducao(2);
    observa(0, 100, p, l, m);
`ifdef EXIBICAO_ACELERADA_EN
    check("r2_pronto_ciclo", p, 18);
    check("r2_leds", l, 6);
`else
    check("r2_pronto_ciclo", p, 24);
    check("r2_leds", l, 12);
`endif
    check("r2_end_max", m, 2);
    espera(3);

    // abort in the middle of playback
    inicia_reproducao(2);
    espera(10);
    abortar = 1'b1;
    espera(1);
    abortar = 1'b0;
    @(negedge clock);
    check("abort_led", int'(mostra_led), 0);
    check("abort_ocupado", int'(ocupado), 0);
    check("abort_db", int'(db_estado), 0);
    espera(20);
    inicia_reproducao(0);
    observa(0, 60, p, l, m);
    check("restart_pronto_ciclo", p, 8);
    check("restart_end_max", m, 0);
    espera(3);

    // iniciar and rodada changes during playback are ignored
    inicia_reproducao(2);
    espera(5);
    iniciar = 1'b1;
    rodada  = 4'd5;
    espera(1);
    iniciar = 1'b0;
    observa(6, 100, p, l, m);
`ifdef EXIBICAO_ACELERADA_EN
    check("ignora_pronto_ciclo", p, 18);
`else
    check("ignora_pronto_ciclo", p, 24);
`endif
    check("ignora_end_max", m, 2);
    espera(3);

    // reset wins over abortar
    inicia_reproducao(1);
    espera(1);
    reset   = 1'b1;
    abortar = 1'b1;
    espera(1);
    reset   = 1'b0;
    abortar = 1'b0;
    @(negedge clock);
    check("rst_abort_endereco", int'(endereco), 0);
    check("rst_abort_led", int'(mostra_led), 0);
    check("rst_abort_ocupado", int'(ocupado), 0);
    check("rst_abort_pronto", int'(pronto), 0);
    check("rst_abort_db", int'(db_estado), 0);
    espera(2);

    // full-range round: last address shown, no wrap
    inicia_reproducao(15);
    observa(0, 400, p, l, m);
`ifdef EXIBICAO_ACELERADA_EN
    check("r15_pronto_ciclo", p, 96);
`else
    check("r15_pronto_ciclo", p, 128);
`endif
    check("r15_end_max", m, 15);
    @(negedge clock);
    check("r15_end_final", int'(endereco), 15);
    check("r15_ocupado_final", int'(ocupado), 0);
    espera(3);

    // on-time as a function of the round
    inicia_reproducao(1);
    observa(0, 100, p, l, m);
`ifdef EXIBICAO_ACELERADA_EN
    check("r1_pronto_ciclo", p, 14);
    check("r1_leds", l, 6);
`else
    check("r1_pronto_ciclo", p, 16);
    check("r1_leds", l, 8);
`endif
    espera(3);

    inicia_reproducao(5);
    observa(0, 200, p, l, m);
`ifdef EXIBICAO_ACELERADA_EN
    check("r5_pronto_ciclo", p, 36);
    check("r5_leds", l, 12);
`else
    check("r5_pronto_ciclo", p, 48);
    check("r5_leds", l, 24);
`endif
    check("r5_end_max", m, 5);
    espera(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
